// File: rtl/fixed_to_float_scheduler_pkg.sv
// Shared definitions for the fixed-to-float conversion scheduler.
//   - default parameter values (channel count, timeout, data width)
//   - FSM state encoding
//   - IEEE-754 single-precision zero used for bypass and abort results
package fixed_to_float_scheduler_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_WIDTH   = 32;

  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fixed_to_float_scheduler_if.sv
// Handshake between the scheduler and the shared converter engine.
//   conv_enable  : start pulse to the engine
//   conv_input   : operand, held while the engine works
//   conv_ready   : engine idle and able to accept
//   conv_done    : one-cycle result-valid pulse
//   conv_output  : engine result
// master = scheduler side, slave = engine side.
interface fixed_to_float_scheduler_if
  import fixed_to_float_scheduler_pkg::*;
  #(parameter int p_WIDTH = DEF_WIDTH) ();

  logic               conv_enable;
  logic [p_WIDTH-1:0] conv_input;
  logic               conv_ready;
  logic               conv_done;
  logic [p_WIDTH-1:0] conv_output;

  modport master (
    output conv_enable,
    output conv_input,
    input  conv_ready,
    input  conv_done,
    input  conv_output
  );

  modport slave (
    input  conv_enable,
    input  conv_input,
    output conv_ready,
    output conv_done,
    output conv_output
  );

endinterface

// File: rtl/fixed_to_float_scheduler_rr_picker.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : index of the last winner; search starts at ptr+1 and wraps
//   gnt : one-hot winner, all zero when nothing is requested
module rr_picker #(
  parameter int p_NUM_REQ = 4,
  parameter int p_IDX_W   = 2
) (
  input  logic [p_NUM_REQ-1:0] req,
  input  logic [p_IDX_W-1:0]   ptr,
  output logic [p_NUM_REQ-1:0] gnt
);

  int   cand;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = 0;
    // Offset 1..N so the last winner is considered last.
    for (int k = 1; k <= p_NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % p_NUM_REQ;
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fixed_to_float_scheduler.sv
// Arbitrates p_NUM_REQ requesters onto one shared fixed-to-float engine.
// Ports:
//   i_CLK, i_RESET_N  : clock, async active-low reset
//   i_REQ, i_REQ_DATA : per-channel level request and signed fixed operand
//   o_GNT             : one-hot pulse once the operand is captured
//   o_RESP_VALID      : one-hot pulse with the result for that channel
//   o_RESP_DATA/ERR   : float result, abort flag (valid with o_RESP_VALID)
//   o_BUSY            : high outside IDLE
//   conv              : engine handshake (master side)
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a request while the engine is ready
// ST_ISSUE   | grant pulse; start engine, or skip it for a zero operand
// ST_WAIT    | engine busy; count cycles until done or timeout
// ST_RESPOND | one-cycle response to the winner, pointer advances
module fixed_to_float_scheduler
  import fixed_to_float_scheduler_pkg::*;
#(
  parameter int p_NUM_REQ = DEF_NUM_REQ,
  parameter int p_TIMEOUT = DEF_TIMEOUT,
  parameter int p_WIDTH   = DEF_WIDTH
) (
  input  logic                         i_CLK,
  input  logic                         i_RESET_N,
  input  logic [p_NUM_REQ-1:0]         i_REQ,
  input  logic [p_NUM_REQ*p_WIDTH-1:0] i_REQ_DATA,
  output logic [p_NUM_REQ-1:0]         o_GNT,
  output logic [p_NUM_REQ-1:0]         o_RESP_VALID,
  output logic [p_WIDTH-1:0]           o_RESP_DATA,
  output logic                         o_RESP_ERR,
  output logic                         o_BUSY,
  fixed_to_float_scheduler_if.master   conv
);

  localparam int IDX_W = idx_width(p_NUM_REQ);
  localparam int CNT_W = (p_TIMEOUT > 1) ? $clog2(p_TIMEOUT) : 1;
  localparam logic [p_WIDTH-1:0] ZERO_W = p_WIDTH'(FLOAT_ZERO);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [p_WIDTH-1:0] operand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [p_WIDTH-1:0] resp_data_q;
  logic               resp_err_q;

  logic [p_NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]     pick_idx;
  logic [p_WIDTH-1:0]   pick_data;
  logic                 take;
  logic                 timeout;
  logic                 operand_zero;

  rr_picker #(
    .p_NUM_REQ (p_NUM_REQ),
    .p_IDX_W   (IDX_W)
  ) u_rr_picker (
    .req (i_REQ),
    .ptr (ptr_q),
    .gnt (pick)
  );

  always_comb begin
    pick_idx  = '0;
    pick_data = '0;
    for (int i = 0; i < p_NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx  = IDX_W'(i);
        pick_data = i_REQ_DATA[i*p_WIDTH +: p_WIDTH];
      end
    end
  end

  assign take         = (state_q == ST_IDLE) && (|i_REQ) && conv.conv_ready;
  assign timeout      = (cnt_q == CNT_W'(p_TIMEOUT - 1));
  assign operand_zero = (operand_q == ZERO_W);

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(p_NUM_REQ - 1);
      idx_q       <= '0;
      operand_q   <= '0;
      cnt_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            operand_q <= pick_data;
            idx_q     <= pick_idx;
          end
        end
        ST_ISSUE: begin
          cnt_q <= '0;
          if (operand_zero) begin
            resp_data_q <= ZERO_W;
            resp_err_q  <= 1'b0;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Done is checked first so a result on the last cycle still counts.
          if (conv.conv_done) begin
            resp_data_q <= conv.conv_output;
            resp_err_q  <= 1'b0;
          end else if (timeout) begin
            resp_data_q <= ZERO_W;
            resp_err_q  <= 1'b1;
          end
        end
        ST_RESPOND: begin
          ptr_q     <= idx_q;
          operand_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d          = state_q;
    o_GNT            = '0;
    o_RESP_VALID     = '0;
    o_RESP_DATA      = '0;
    o_RESP_ERR       = 1'b0;
    o_BUSY           = (state_q != ST_IDLE);
    conv.conv_enable = 1'b0;
    conv.conv_input  = '0;

    case (state_q)
      ST_IDLE: begin
        if (take) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        o_GNT = p_NUM_REQ'(1) << idx_q;
        if (operand_zero) begin
          state_d = ST_RESPOND;
        end else begin
          conv.conv_enable = 1'b1;
          conv.conv_input  = operand_q;
          state_d          = ST_WAIT;
        end
      end
      ST_WAIT: begin
        conv.conv_input = operand_q;
        if (conv.conv_done || timeout) state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        o_RESP_VALID = p_NUM_REQ'(1) << idx_q;
        o_RESP_DATA  = resp_data_q;
        o_RESP_ERR   = resp_err_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fixed_to_float_scheduler.sv
// Scoreboard bench for fixed_to_float_scheduler with a behavioural engine.
module tb_fixed_to_float_scheduler;

  logic         i_CLK = 1'b0;
  logic         i_RESET_N;
  logic [3:0]   i_REQ;
  logic [127:0] i_REQ_DATA;
  logic [3:0]   o_GNT;
  logic [3:0]   o_RESP_VALID;
  logic [31:0]  o_RESP_DATA;
  logic         o_RESP_ERR;
  logic         o_BUSY;

  fixed_to_float_scheduler_if #(.p_WIDTH(32)) conv_if ();

  fixed_to_float_scheduler #(
    .p_NUM_REQ (4),
    .p_TIMEOUT (64),
    .p_WIDTH   (32)
  ) dut (
    .i_CLK        (i_CLK),
    .i_RESET_N    (i_RESET_N),
    .i_REQ        (i_REQ),
    .i_REQ_DATA   (i_REQ_DATA),
    .o_GNT        (o_GNT),
    .o_RESP_VALID (o_RESP_VALID),
    .o_RESP_DATA  (o_RESP_DATA),
    .o_RESP_ERR   (o_RESP_ERR),
    .o_BUSY       (o_BUSY),
    .conv         (conv_if)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int cyc_req = 0;
  int last_resp_cyc = 0;
  int resp_cnt = 0;
  int gnt_cnt = 0;
  int en_cnt = 0;
  int wait_cnt = 0;
  logic [3:0] gnt_hist [0:63];

  int          eng_delay = 28;
  int          eng_cnt = 0;
  logic        eng_pend = 1'b0;
  logic [31:0] eng_res = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Engine model: truncating signed-integer to single-precision conversion.
  function automatic logic [31:0] int_to_float(input logic [31:0] v);
    logic        s;
    logic [31:0] a;
    logic [31:0] sh;
    int          msb;
    s   = v[31];
    a   = s ? (~v + 32'd1) : v;
    msb = 0;
    if (a == 32'd0) return 32'd0;
    for (int i = 0; i < 32; i++) if (a[i]) msb = i;
    sh = a << (31 - msb);
    return {s, 8'(127 + msb), sh[30:8]};
  endfunction

  always @(posedge i_CLK) cyc++;

  // Behavioural converter: done arrives eng_delay cycles after the start
  // pulse; eng_delay == 0 means the engine never answers.
  always @(negedge i_CLK) begin
    conv_if.conv_done = 1'b0;
    if (conv_if.conv_enable) begin
      eng_pend = 1'b1;
      eng_cnt  = eng_delay;
      eng_res  = int_to_float(conv_if.conv_input);
    end else if (eng_pend && eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        conv_if.conv_done   = 1'b1;
        conv_if.conv_output = eng_res;
        eng_pend            = 1'b0;
      end
    end
  end

  always @(negedge i_CLK) begin
    if (o_GNT != 4'd0) begin
      if (gnt_cnt < 64) gnt_hist[gnt_cnt] = o_GNT;
      gnt_cnt++;
    end
    if (conv_if.conv_enable) en_cnt++;
    if (o_BUSY && !conv_if.conv_enable && conv_if.conv_input != 32'd0) wait_cnt++;
    if (o_RESP_VALID != 4'd0) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      if (sb.size() == 0) begin
        check_eq("unexpected_resp", {60'd0, o_RESP_VALID}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("resp_valid", {60'd0, o_RESP_VALID}, {60'd0, mon_e.vld});
        check_eq("resp_data", {32'd0, o_RESP_DATA}, {32'd0, mon_e.data});
        check_eq("resp_err", {63'd0, o_RESP_ERR}, {63'd0, mon_e.err});
      end
    end
  end

  task automatic tick();
    @(negedge i_CLK);
    #1;
  endtask

  task automatic send(input int ch, input logic [31:0] val,
                      input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    e.vld  = 4'(1 << ch);
    e.data = exp_data;
    e.err  = exp_err;
    sb.push_back(e);
    i_REQ_DATA[ch*32 +: 32] = val;
    i_REQ[ch] = 1'b1;
    cyc_req = cyc;
  endtask

  task automatic drop_on_gnt(input int budget);
    int n;
    n = 0;
    while (i_REQ != 4'd0 && n < budget) begin
      tick();
      i_REQ = i_REQ & ~o_GNT;
      n++;
    end
    if (i_REQ != 4'd0) begin
      check_eq("gnt_timeout", {60'd0, i_REQ}, 64'd0);
      i_REQ = '0;
    end
  endtask

  task automatic wait_resp(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("resp_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    tick();
  endtask

  task automatic do_reset();
    i_RESET_N = 1'b0;
    tick();
    tick();
    i_RESET_N = 1'b1;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    int gbase, ebase, wbase, rbase, n;
    logic re_done;
    logic [3:0] exp_order [5];

    i_RESET_N  = 1'b0;
    i_REQ      = '0;
    i_REQ_DATA = '0;
    conv_if.conv_ready  = 1'b1;
    conv_if.conv_done   = 1'b0;
    conv_if.conv_output = '0;
    tick();
    tick();
    i_RESET_N = 1'b1;
    tick();

    check_eq("reset_ctrl", {57'd0, o_GNT, o_RESP_VALID[2:0]}, 64'd0);
    check_eq("reset_busy", {62'd0, o_BUSY, conv_if.conv_enable}, 64'd0);
    check_eq("reset_input", {32'd0, conv_if.conv_input}, 64'd0);

    // ch1 converts 5 with a 28-cycle engine
    gbase = gnt_cnt;
    eng_delay = 28;
    send(1, 32'd5, 32'h40A0_0000, 1'b0);
    drop_on_gnt(10);
    check_eq("gnt_ch1", {60'd0, gnt_hist[gbase]}, 64'h2);
    wait_resp(100);

    // minimum non-bypass latency, engine answers in the first WAIT cycle
    eng_delay = 1;
    send(2, 32'd7, 32'h40E0_0000, 1'b0);
    drop_on_gnt(10);
    wait_resp(20);
    check_eq("min_latency", 64'(last_resp_cyc - cyc_req + 1), 64'd4);

    // all four at once after reset, ch0 re-requests after its first grant
    do_reset();
    eng_delay = 3;
    gbase = gnt_cnt;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    send(0, 32'd100, 32'h42C8_0000, 1'b0);
    send(1, 32'hFFFF_FFFD, 32'hC040_0000, 1'b0);
    send(2, 32'd1, 32'h3F80_0000, 1'b0);
    send(3, 32'd12345, 32'h4640_E400, 1'b0);
    begin
      exp_t e;
      e.vld = 4'b0001; e.data = 32'h4000_0000; e.err = 1'b0;
      sb.push_back(e);
    end
    re_done = 1'b0;
    n = 0;
    while ((i_REQ != 4'd0 || !re_done) && n < 300) begin
      tick();
      n++;
      i_REQ = i_REQ & ~o_GNT;
      if (o_GNT[0] && !re_done) begin
        i_REQ_DATA[31:0] = 32'd2;
        i_REQ[0] = 1'b1;
        re_done = 1'b1;
      end
    end
    wait_resp(100);
    for (int k = 0; k < 5; k++)
      check_eq($sformatf("gnt_order%0d", k), {60'd0, gnt_hist[gbase+k]}, {60'd0, exp_order[k]});

    // engine never answers: abort after 64 WAIT cycles
    eng_delay = 0;
    wbase = wait_cnt;
    send(1, 32'd9, 32'd0, 1'b1);
    drop_on_gnt(10);
    wait_resp(200);
    check_eq("timeout_wait_cycles", 64'(wait_cnt - wbase), 64'd64);

    eng_delay = 4;
    send(0, 32'd1, 32'h3F80_0000, 1'b0);
    drop_on_gnt(10);
    wait_resp(50);

    // done lands on the final WAIT cycle: result wins over the abort
    eng_delay = 64;
    wbase = wait_cnt;
    send(3, 32'd3, 32'h4040_0000, 1'b0);
    drop_on_gnt(10);
    wait_resp(200);
    check_eq("coincide_wait_cycles", 64'(wait_cnt - wbase), 64'd64);

    // reset during WAIT cycle 10: no response, late done is ignored
    eng_delay = 40;
    rbase = resp_cnt;
    wbase = wait_cnt;
    i_REQ_DATA[32 +: 32] = 32'd7;
    i_REQ[1] = 1'b1;
    drop_on_gnt(10);
    n = 0;
    while (wait_cnt - wbase < 10 && n < 50) begin
      tick();
      n++;
    end
    check_eq("reached_wait10", 64'(wait_cnt - wbase), 64'd10);
    i_RESET_N = 1'b0;
    #1;
    check_eq("rst_mid_ctrl", {54'd0, o_GNT, o_RESP_VALID, o_RESP_ERR, o_BUSY}, 64'd0);
    check_eq("rst_mid_data", {32'd0, o_RESP_DATA}, 64'd0);
    check_eq("rst_mid_conv", {31'd0, conv_if.conv_enable, conv_if.conv_input}, 64'd0);
    tick();
    i_RESET_N = 1'b1;
    for (int k = 0; k < 50; k++) tick();
    check_eq("rst_no_resp", 64'(resp_cnt - rbase), 64'd0);
    check_eq("rst_idle", {63'd0, o_BUSY}, 64'd0);

    // engine not ready: ch3 waits for ready
    conv_if.conv_ready = 1'b0;
    gbase = gnt_cnt;
    eng_delay = 2;
    send(3, 32'd4, 32'h4080_0000, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    check_eq("no_gnt_not_ready", 64'(gnt_cnt - gbase), 64'd0);
    check_eq("idle_not_ready", {63'd0, o_BUSY}, 64'd0);
    conv_if.conv_ready = 1'b1;
    drop_on_gnt(10);
    check_eq("gnt_ch3", {60'd0, gnt_hist[gbase]}, 64'h8);
    wait_resp(30);

    // zero operand bypasses the engine
    ebase = en_cnt;
    send(2, 32'd0, 32'd0, 1'b0);
    drop_on_gnt(10);
    wait_resp(20);
    check_eq("bypass_latency", 64'(last_resp_cyc - cyc_req + 1), 64'd3);
    check_eq("bypass_no_enable", 64'(en_cnt - ebase), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
